// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the bit-serial adder sequencer.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow flag ovf.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin_init,
    input  busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin_init,
    output busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition sequencer driving one external combinational full adder, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_adder_ctrl_if.slave     bus,
  output logic                   fa_x,
  output logic                   fa_y,
  output logic                   fa_cin,
  input  logic                   fa_sum,
  input  logic                   fa_cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] s_sh_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_r;
`endif

  logic             run_s;
  logic [WIDTH-1:0] s_next_s;

  assign run_s    = (state_r == RUN);
  assign s_next_s = {fa_sum, s_sh_r[WIDTH-1:1]};

  // Full-adder operands come straight from the shift registers and are forced low outside RUN.
  assign fa_x   = run_s & a_sh_r[0];
  assign fa_y   = run_s & b_sh_r[0];
  assign fa_cin = run_s & carry_r;

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_r;
`endif

  // Sequencer: capture on start, shift one bit per clock, publish the result on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      s_sh_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      count_r <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            carry_r <= bus.cin_init;
            s_sh_r  <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          s_sh_r  <= s_next_s;
          carry_r <= fa_cout;
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          count_r <= count_r + CW'(1);
          if (count_r == LAST_BIT) begin
            sum_r   <= s_next_s;
            cout_r  <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf_r   <= carry_r ^ fa_cout;
`endif
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl with a behavioural full adder.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic fa_x, fa_y, fa_cin, fa_sum, fa_cout;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] prev_sum  = 8'h00;
  logic       prev_cout = 1'b0;

  serial_adder_ctrl_if #(.WIDTH(8)) bus();

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .fa_x   (fa_x),
    .fa_y   (fa_y),
    .fa_cin (fa_cin),
    .fa_sum (fa_sum),
    .fa_cout(fa_cout)
  );

  // External full-adder cell.
  assign fa_sum  = fa_x ^ fa_y ^ fa_cin;
  assign fa_cout = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);

  always #5 clk = ~clk;

  // One operation, entered and left 1ns after an edge with the DUT in IDLE.
  task automatic op(input string name, input logic [7:0] av, input logic [7:0] bv,
                    input logic ci, input logic [7:0] es, input logic ec,
                    input logic eo, input int inject);
    logic       c;
    logic [4:0] got;
    logic [4:0] exp;
    bus.a = av; bus.b = bv; bus.cin_init = ci; bus.start = 1'b1;
    @(posedge clk); #1;
    c = ci;
    for (int i = 0; i < 8; i++) begin
      exp = {av[i], bv[i], c, 1'b1, 1'b0};
      got = {fa_x, fa_y, fa_cin, bus.busy, bus.done};
      total++;
      if (got !== exp)
        $display("FAIL %s bit%0d {fa_x,fa_y,fa_cin,busy,done} got=%b exp=%b", name, i, got, exp);
      total++;
      if ({bus.cout, bus.sum} !== {prev_cout, prev_sum})
        $display("FAIL %s held_bit%0d got=%h exp=%h", name, i, {bus.cout, bus.sum}, {prev_cout, prev_sum});
      if ({bus.cout, bus.sum} !== {prev_cout, prev_sum}) bad++;
      if (got !== exp) bad++;
      bus.start = (i == inject);
      if (i == inject) bus.a = 8'h11;
      c = (av[i] & bv[i]) | (av[i] & c) | (bv[i] & c);
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.a = av;
    total++;
    if ({bus.busy, bus.done} !== 2'b11) begin
      bad++; $display("FAIL %s done_pulse got=%b exp=11", name, {bus.busy, bus.done});
    end
    total++;
    if (bus.sum !== es) begin
      bad++; $display("FAIL %s sum got=%h exp=%h", name, bus.sum, es);
    end
    total++;
    if (bus.cout !== ec) begin
      bad++; $display("FAIL %s cout got=%b exp=%b", name, bus.cout, ec);
    end
`ifdef SERIAL_ADD_OVF_EN
    total++;
    if (bus.ovf !== eo) begin
      bad++; $display("FAIL %s ovf got=%b exp=%b", name, bus.ovf, eo);
    end
`endif
    @(posedge clk); #1;
    total++;
    if ({bus.busy, bus.done, fa_x, fa_y, fa_cin, bus.cout, bus.sum} !== {5'b00000, ec, es}) begin
      bad++;
      $display("FAIL %s after_done got=%h exp=%h", name,
               {bus.busy, bus.done, fa_x, fa_y, fa_cin, bus.cout, bus.sum}, {5'b00000, ec, es});
    end
    prev_sum = es; prev_cout = ec;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00; bus.cin_init = 1'b0;
    #12;
    total++;
    if ({bus.busy, bus.done, bus.cout, bus.sum, fa_x, fa_y, fa_cin} !== 14'd0) begin
      bad++; $display("FAIL reset_state got=%h exp=0", {bus.busy, bus.done, bus.cout, bus.sum, fa_x, fa_y, fa_cin});
    end
`ifdef SERIAL_ADD_OVF_EN
    total++;
    if (bus.ovf !== 1'b0) begin
      bad++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++; $display("FAIL reset_idle got=%b exp=00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_basic();
    op("basic_3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, -1);
  endtask

  task automatic test_carry();
    op("carry_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
    op("cin_only",    8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, -1);
  endtask

  task automatic test_overflow();
    op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1);
    op("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1);
  endtask

  task automatic test_ignore_start();
    op("ignore_start", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0, 3);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL ignore_start_not_queued busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    bus.a = 8'h3C; bus.b = 8'h0F; bus.cin_init = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.cout, bus.sum, fa_x, fa_y, fa_cin} !== 14'd0) begin
      bad++; $display("FAIL abort_outputs got=%h exp=0", {bus.busy, bus.done, bus.cout, bus.sum, fa_x, fa_y, fa_cin});
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        @(negedge clk); rst_n = 1'b1;
      end
      total++;
      if (bus.done !== 1'b0) begin
        bad++; $display("FAIL abort_no_done cyc%0d got=%b exp=0", i, bus.done);
      end
    end
    prev_sum = 8'h00; prev_cout = 1'b0;
    op("after_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bus.a = 8'h10; bus.b = 8'h20; bus.cin_init = 1'b0; bus.start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        total++;
        if (c !== 8 + 10 * n) begin
          bad++; $display("FAIL b2b_spacing pulse%0d cycle got=%0d exp=%0d", n, c, 8 + 10 * n);
        end
        total++;
        if ({bus.cout, bus.sum} !== 9'h030) begin
          bad++; $display("FAIL b2b_sum pulse%0d got=%h exp=030", n, {bus.cout, bus.sum});
        end
        n++;
      end
    end
    bus.start = 1'b0;
    total++;
    if (n !== 3) begin
      bad++; $display("FAIL b2b_count got=%0d exp=3", n);
    end
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle busy got=%b exp=0", bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the sequence above is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
